// File: rtl/prog_loader_if.sv
// Byte-stream handshake and program-memory port of the program loader.
// The loader attaches through the slave modport; the stream source / memory side uses master.
interface prog_loader_if #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 4
);
    logic [7:0]           byte_in;
    logic                 byte_valid;
    logic                 byte_ready;
    logic                 mem_w;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_data_wr;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  mem_w,
        input  mem_addr,
        input  mem_data_wr
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output mem_w,
        output mem_addr,
        output mem_data_wr
    );
endinterface

// File: rtl/prog_loader.sv
// Assembles a big-endian byte stream into instruction words and writes them to program
// memory from address 0, holding the core while loading and passing fetch addresses when idle.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | memory port belongs to the core; waiting for start
// ST_COLLECT | accepting bytes of the current word
// ST_WRITE   | one-cycle write of the assembled word at word_cnt
// ST_DONE    | one-cycle done pulse, then back to idle
module prog_loader #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_SIZE:0]   len,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    output logic                 cpu_hold,
    output logic                 done,
    prog_loader_if.slave         bus
);
    localparam int BPW = DATA_SIZE / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_SIZE:0] CAP = (ADDR_SIZE+1)'(2 ** ADDR_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [ADDR_SIZE:0]   len_r;
    logic [ADDR_SIZE:0]   word_cnt;
    logic [BCW-1:0]       byte_cnt;
    logic [DATA_SIZE-1:0] asm_word;

    logic [ADDR_SIZE:0]   len_clamped;
    logic [DATA_SIZE-1:0] byte_ext;
    logic                 last_byte;
    logic                 last_word;

    // Clamp so the session never wraps back onto already-written low addresses.
    assign len_clamped = (len > CAP) ? CAP : len;
    assign byte_ext    = DATA_SIZE'(bus.byte_in);
    assign last_byte   = (byte_cnt == BCW'(BPW - 1));
    assign last_word   = (word_cnt == len_r - 1'b1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_r    <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_r    <= len_clamped;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                ST_COLLECT: begin
                    // byte_ready is high throughout COLLECT, so valid alone completes the handshake.
                    if (bus.byte_valid) begin
                        asm_word <= (asm_word << 8) | byte_ext;
                        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!last_word) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len_clamped == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus.byte_valid && last_byte) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_nxt = last_word ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready  = 1'b0;
        bus.mem_w       = 1'b0;
        bus.mem_addr    = word_cnt[ADDR_SIZE-1:0];
        bus.mem_data_wr = asm_word;
        cpu_hold        = 1'b1;
        done            = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.mem_addr = cpu_addr;
                cpu_hold     = 1'b0;
            end
            ST_COLLECT: bus.byte_ready = 1'b1;
            ST_WRITE:   bus.mem_w      = 1'b1;
            ST_DONE:    done           = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: stream driver, registered-read program memory,
// output monitor, and a word-list reference model built from the byte stimulus.
module tb_prog_loader;
    localparam int DS  = 16;
    localparam int AS  = 4;
    localparam int BPW = DS / 8;
    localparam int CAP = 2 ** AS;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AS:0]   len = '0;
    logic [AS-1:0] cpu_addr = '0;
    logic          cpu_hold;
    logic          done;

    int total = 0;
    int bad = 0;

    prog_loader_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) bus ();

    prog_loader #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .len      (len),
        .cpu_addr (cpu_addr),
        .cpu_hold (cpu_hold),
        .done     (done),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // program memory with registered read
    logic [DS-1:0] mem [CAP];
    logic [DS-1:0] mem_rd;
    logic          mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < CAP; i++) mem[i] <= '0;
        end else if (bus.mem_w) begin
            mem[bus.mem_addr] <= bus.mem_data_wr;
        end
        mem_rd <= mem[bus.mem_addr];
    end

    // byte stream driver
    logic [7:0] byte_q[$];
    int  gap = 0;
    int  gap_left = 0;
    bit  acc_pending = 0;
    bit  force_valid = 0;
    int  acc_total = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            byte_q.delete();
            acc_pending = 0;
            gap_left = 0;
        end
        if (acc_pending && byte_q.size() > 0) begin
            void'(byte_q.pop_front());
            acc_total++;
            gap_left = gap;
        end
        acc_pending = 0;
        if (force_valid || (byte_q.size() > 0 && gap_left == 0)) begin
            bus.byte_valid = 1'b1;
            bus.byte_in = (byte_q.size() > 0) ? byte_q[0] : 8'hEE;
        end else begin
            bus.byte_valid = 1'b0;
            bus.byte_in = 8'h00;
            if (gap_left > 0) gap_left--;
        end
        acc_pending = bus.byte_valid && bus.byte_ready && rstn;
    end

    // monitor, sampled 1ns after each rising edge
    int            cyc = 0;
    int            wr_addr[$];
    logic [DS-1:0] wr_data[$];
    int            wr_cyc[$];
    int            done_cyc[$];
    int            hold_rise[$];
    int            hold_cyc = 0;
    int            gap_ready = 0;
    int            idle_viol = 0;
    bit            prev_hold = 0;
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (rstn) begin
            if (bus.mem_w) begin
                wr_addr.push_back(int'(bus.mem_addr));
                wr_data.push_back(bus.mem_data_wr);
                wr_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (cpu_hold) hold_cyc++;
            if (cpu_hold && !prev_hold) hold_rise.push_back(cyc);
            if (bus.byte_ready && !bus.byte_valid) gap_ready++;
            if (!cpu_hold && (bus.mem_w || bus.byte_ready || bus.mem_addr !== cpu_addr)) idle_viol++;
        end
        prev_hold = cpu_hold;
    end

    logic [7:0] stim[$];

    task automatic clear_rec();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc.delete();
        hold_rise.delete();
        hold_cyc = 0;
        gap_ready = 0;
    endtask

    task automatic gen_stim(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            stim.push_back(b);
            byte_q.push_back(b);
        end
    endtask

    task automatic run_session(input logic [AS:0] l, input int max_cyc, output bit to);
        int d0;
        d0 = done_cyc.size();
        @(negedge clk);
        start = 1'b1;
        len = l;
        @(negedge clk);
        start = 1'b0;
        to = 1;
        for (int i = 0; i < max_cyc; i++) begin
            if (done_cyc.size() > d0) begin
                to = 0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        force_valid = 1;
        start = 1'b1;
        cpu_addr = 4'd5;
        repeat (3) @(negedge clk);
        total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL rst_byte_ready got=%b want=0", bus.byte_ready); end
        total++; if (bus.mem_w !== 1'b0) begin bad++; $display("FAIL rst_mem_w got=%b want=0", bus.mem_w); end
        total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL rst_cpu_hold got=%b want=0", cpu_hold); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (bus.mem_addr !== 4'd5) begin bad++; $display("FAIL rst_mem_addr got=%0d want=5", bus.mem_addr); end
        start = 1'b0;
        force_valid = 0;
        mem_clr = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        cpu_addr = 4'd9;
        repeat (2) @(negedge clk);
        total++; if (bus.mem_addr !== 4'd9 || cpu_hold !== 1'b0) begin bad++; $display("FAIL idle_pass got=%0d/%b want=9/0", bus.mem_addr, cpu_hold); end
    endtask

    task automatic test_continuous();
        bit to;
        int a0;
        clear_rec();
        gap = 0;
        stim = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        foreach (stim[i]) byte_q.push_back(stim[i]);
        a0 = acc_total;
        repeat (3) @(negedge clk);
        total++; if (acc_total != a0 || byte_q.size() != 4) begin bad++; $display("FAIL idle_no_consume got=%0d want=0", acc_total - a0); end
        run_session(2, 50, to);
        total++; if (to) begin bad++; $display("FAIL cont_timeout got=no_done want=done"); end
        total++; if (wr_addr.size() != 2) begin bad++; $display("FAIL cont_wr_count got=%0d want=2", wr_addr.size()); end
        for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
            total++;
            if (wr_addr[i] != i || wr_data[i] !== {stim[2*i], stim[2*i+1]})
                begin bad++; $display("FAIL cont_wr%0d got=%0d:%h want=%0d:%h", i, wr_addr[i], wr_data[i], i, {stim[2*i], stim[2*i+1]}); end
        end
        if (wr_cyc.size() == 2 && done_cyc.size() == 1 && hold_rise.size() == 1) begin
            total++; if (wr_cyc[0] != hold_rise[0] + BPW) begin bad++; $display("FAIL cont_first_wr_lat got=%0d want=%0d", wr_cyc[0] - hold_rise[0], BPW); end
            total++; if (wr_cyc[1] - wr_cyc[0] != BPW + 1) begin bad++; $display("FAIL cont_wr_spacing got=%0d want=%0d", wr_cyc[1] - wr_cyc[0], BPW + 1); end
            total++; if (done_cyc[0] != wr_cyc[1] + 1) begin bad++; $display("FAIL cont_done_lat got=%0d want=1", done_cyc[0] - wr_cyc[1]); end
        end else begin
            total++; bad++; $display("FAIL cont_events got=%0d/%0d/%0d want=2/1/1", wr_cyc.size(), done_cyc.size(), hold_rise.size());
        end
        @(negedge clk);
        total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL cont_hold_drop got=%b want=0", cpu_hold); end
        total++; if (hold_cyc != 2 * (BPW + 1) + 1) begin bad++; $display("FAIL cont_hold_cycles got=%0d want=%0d", hold_cyc, 2 * (BPW + 1) + 1); end
        cpu_addr = 4'd1;
        @(negedge clk);
        total++; if (mem_rd !== 16'hABCD) begin bad++; $display("FAIL cont_readback got=%h want=abcd", mem_rd); end
    endtask

    task automatic test_bubble();
        bit to;
        clear_rec();
        gap = 2;
        stim = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        foreach (stim[i]) byte_q.push_back(stim[i]);
        run_session(2, 100, to);
        total++; if (to) begin bad++; $display("FAIL bub_timeout got=no_done want=done"); end
        total++; if (wr_addr.size() != 2) begin bad++; $display("FAIL bub_wr_count got=%0d want=2", wr_addr.size()); end
        for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
            total++;
            if (wr_addr[i] != i || wr_data[i] !== {stim[2*i], stim[2*i+1]})
                begin bad++; $display("FAIL bub_wr%0d got=%0d:%h want=%0d:%h", i, wr_addr[i], wr_data[i], i, {stim[2*i], stim[2*i+1]}); end
        end
        total++; if (gap_ready < 4) begin bad++; $display("FAIL bub_ready_in_gaps got=%0d want=>=4", gap_ready); end
        gap = 0;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        bit to;
        clear_rec();
        run_session(0, 10, to);
        repeat (5) @(negedge clk);
        total++; if (to) begin bad++; $display("FAIL zero_timeout got=no_done want=done"); end
        total++; if (wr_addr.size() != 0) begin bad++; $display("FAIL zero_writes got=%0d want=0", wr_addr.size()); end
        total++; if (hold_cyc != 1) begin bad++; $display("FAIL zero_hold got=%0d want=1", hold_cyc); end
        total++;
        if (done_cyc.size() != 1 || hold_rise.size() != 1 || done_cyc[0] != hold_rise[0])
            begin bad++; $display("FAIL zero_done got=%0d pulses want=1 in first hold cycle", done_cyc.size()); end
    endtask

    task automatic test_clamp();
        bit to;
        clear_rec();
        gap = 0;
        gen_stim(CAP * BPW);
        @(negedge clk);
        start = 1'b1;
        len = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        len = 5'd3;
        @(negedge clk);
        start = 1'b0;
        to = 1;
        for (int i = 0; i < 200; i++) begin
            if (done_cyc.size() > 0) begin to = 0; break; end
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        total++; if (to) begin bad++; $display("FAIL clamp_timeout got=no_done want=done"); end
        total++; if (wr_addr.size() != CAP) begin bad++; $display("FAIL clamp_wr_count got=%0d want=%0d", wr_addr.size(), CAP); end
        for (int i = 0; i < CAP && i < wr_addr.size(); i++) begin
            total++;
            if (wr_addr[i] != i || wr_data[i] !== {stim[2*i], stim[2*i+1]})
                begin bad++; $display("FAIL clamp_wr%0d got=%0d:%h want=%0d:%h", i, wr_addr[i], wr_data[i], i, {stim[2*i], stim[2*i+1]}); end
        end
        total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL clamp_done_pulses got=%0d want=1", done_cyc.size()); end
        total++; if (hold_cyc != CAP * (BPW + 1) + 1) begin bad++; $display("FAIL clamp_hold got=%0d want=%0d", hold_cyc, CAP * (BPW + 1) + 1); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int a0;
        logic [DS-1:0] m1;
        clear_rec();
        gap = 0;
        m1 = mem[1];
        a0 = acc_total;
        gen_stim(2 * BPW);
        @(negedge clk);
        start = 1'b1;
        len = 5'd2;
        @(negedge clk);
        start = 1'b0;
        to = 1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (acc_total == a0 + BPW + 1) begin to = 0; break; end
            @(negedge clk);
        end
        rstn = 1'b0;
        total++; if (to) begin bad++; $display("FAIL mid_wait got=%0d bytes want=%0d", acc_total - a0, BPW + 1); end
        @(negedge clk);
        #1;
        total++; if (cpu_hold !== 1'b0 || bus.mem_w !== 1'b0) begin bad++; $display("FAIL mid_abort got=%b/%b want=0/0", cpu_hold, bus.mem_w); end
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (wr_addr.size() != 1) begin bad++; $display("FAIL mid_wr_count got=%0d want=1", wr_addr.size()); end
        total++; if (mem[1] !== m1) begin bad++; $display("FAIL mid_addr1 got=%h want=%h", mem[1], m1); end
        total++; if (cpu_hold !== 1'b0 || byte_q.size() != 0) begin bad++; $display("FAIL mid_idle got=%b/%0d want=0/0", cpu_hold, byte_q.size()); end
        clear_rec();
        stim = '{8'h5A, 8'hA5};
        foreach (stim[i]) byte_q.push_back(stim[i]);
        run_session(1, 50, to);
        @(negedge clk);
        total++; if (to) begin bad++; $display("FAIL mid_reload_timeout got=no_done want=done"); end
        total++;
        if (wr_addr.size() != 1 || wr_addr[0] != 0 || wr_data[0] !== 16'h5AA5)
            begin bad++; $display("FAIL mid_reload_wr got=%0d writes want=1 at 0 data 5aa5", wr_addr.size()); end
        total++; if (mem[0] !== 16'h5AA5) begin bad++; $display("FAIL mid_reload_mem got=%h want=5aa5", mem[0]); end
    endtask

    task automatic test_random();
        bit to;
        int l, n;
        for (int s = 0; s < 5; s++) begin
            clear_rec();
            l = $urandom_range(0, 20);
            n = (l > CAP) ? CAP : l;
            gap = $urandom_range(0, 2);
            gen_stim(n * BPW);
            run_session(5'(l), 400, to);
            repeat (3) @(negedge clk);
            total++; if (to) begin bad++; $display("FAIL rnd%0d_timeout got=no_done want=done", s); end
            total++; if (wr_addr.size() != n) begin bad++; $display("FAIL rnd%0d_wr_count got=%0d want=%0d", s, wr_addr.size(), n); end
            for (int i = 0; i < n && i < wr_addr.size(); i++) begin
                total++;
                if (wr_addr[i] != i || wr_data[i] !== {stim[2*i], stim[2*i+1]})
                    begin bad++; $display("FAIL rnd%0d_wr%0d got=%0d:%h want=%0d:%h", s, i, wr_addr[i], wr_data[i], i, {stim[2*i], stim[2*i+1]}); end
            end
            total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL rnd%0d_done got=%0d want=1", s, done_cyc.size()); end
        end
        gap = 0;
        total++; if (idle_viol != 0) begin bad++; $display("FAIL idle_outputs got=%0d bad cycles want=0", idle_viol); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_bubble();
        test_zero_len();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream stage of the program memory: receives a byte stream (e.g. from a UART/debug port) and assembles it into DATA_SIZE-bit instruction words.
- Writes the words to consecutive program-memory addresses starting at 0.
- While idle, passes the core's fetch address straight through to the memory, so one memory port serves both loading and fetch.
- Holds the core in reset-like stall (`cpu_hold`) for the duration of a load.

Parameters:
- DATA_SIZE, 16: instruction word width; must be a multiple of 8. BPW = DATA_SIZE/8 bytes per word.
- ADDR_SIZE, 4: program memory address width; capacity is 2**ADDR_SIZE words.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  begin a load session; sampled only in IDLE.
- len  in  ADDR_SIZE+1  number of words to load; sampled with start.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- cpu_addr  in  ADDR_SIZE  fetch address from the core.
- mem_w  out  1  program-memory write enable.
- mem_addr  out  ADDR_SIZE  program-memory address.
- mem_data_wr  out  DATA_SIZE  program-memory write data.
- cpu_hold  out  1  high while a load is in progress (states other than IDLE).
- done  out  1  one-cycle pulse when a session completes.

Behaviour:
- Clock and reset: single clock domain `clk`. Reset `rstn` is asynchronous, active-low. All state is reset on the async edge.
- Reset values:
  - state = IDLE.
  - word_cnt, byte_cnt, len_r and the assembly register are 0.
  - byte_ready = 0, mem_w = 0, cpu_hold = 0, done = 0.
  - mem_addr = cpu_addr (IDLE pass-through), mem_data_wr = 0.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - mem_addr = cpu_addr (combinational), mem_w = 0, byte_ready = 0.
  - On start = 1: len_r = min(len, 2**ADDR_SIZE). Go to DONE if len_r == 0, else go to COLLECT. word_cnt and byte_cnt are cleared.
- COLLECT:
  - byte_ready = 1.
  - Handshake: a byte is accepted on an edge where byte_valid && byte_ready.
  - Bytes are big-endian: the first byte of a word lands in bits [DATA_SIZE-1:DATA_SIZE-8].
  - byte_cnt increments on each accepted byte. When byte BPW-1 is accepted, go to WRITE and clear byte_cnt.
  - If byte_valid = 0, hold state.
- WRITE (exactly one cycle):
  - mem_w = 1, mem_addr = word_cnt[ADDR_SIZE-1:0], mem_data_wr = assembled word, byte_ready = 0.
  - At the edge: if word_cnt == len_r-1, go to DONE; else increment word_cnt and go to COLLECT.
- DONE (one cycle):
  - done = 1, mem_w = 0.
  - Go to IDLE at the next edge.
- cpu_hold = (state != IDLE).
- mem_addr outside IDLE: equals word_cnt[ADDR_SIZE-1:0].
- Throughput: with byte_valid held high, each word takes BPW+1 cycles (BPW collect cycles plus 1 write cycle).
- Memory interaction: the memory captures the write at the edge ending the WRITE cycle. After return to IDLE, a read of cpu_addr returns data one edge later, because the memory read is registered.
- Boundary conditions:
  - start asserted outside IDLE is ignored.
  - len > 2**ADDR_SIZE is clamped; addresses never wrap.
  - len == 0 produces a done pulse with no memory write.
  - Bytes presented outside COLLECT are not consumed (byte_ready = 0).
  - rstn deasserted mid-session aborts immediately: the partial word is discarded, no further writes occur, and memory contents already written are not touched by this block.
  - A start in the same cycle as done (DONE state) is ignored. start must be reasserted in IDLE.

Test Plan:
- Reset: hold rstn = 0 with start = 1 and byte_valid = 1 → byte_ready = 0, mem_w = 0, cpu_hold = 0, done = 0, mem_addr follows cpu_addr = 5.
- Continuous load, start with len = 2; bytes 0x12, 0x34, 0xAB, 0xCD with byte_valid held high →
  - mem_w pulses at addr 0 data 0x1234, then 3 cycles later at addr 1 data 0xABCD.
  - done pulses the next cycle; cpu_hold then drops.
  - Setting cpu_addr = 1 reads 0xABCD from memory one cycle later.
- Bubbled stream: same data with byte_valid low for 2 cycles between each byte → identical writes; no mem_w until both bytes of a word are accepted; byte_ready stays high through the gaps.
- Zero length: len = 0 → done pulses 1 cycle after start; mem_w is never asserted; cpu_hold is high for exactly 1 cycle.
- Clamp and ignore: len = 20 with ADDR_SIZE = 4 and a second start mid-session →
  - exactly 16 writes to addresses 0..15, data matching the stream, then a single done pulse;
  - the second start has no effect.
- Reset mid-operation: pulse rstn low after the first byte of word 1 → returns to IDLE with no write to addr 1. A new start with len = 1 and bytes 0x5A, 0xA5 then writes 0x5AA5 at addr 0.
